// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: owns the single register-file write port at writeback.
// Pipeline writes always win the slot. A multi-cycle MDU result that loses the
// slot is parked in a 1-entry holding register and written on the next free
// slot. After STARVE_MAX consecutive lost slots, stall_req asks pipeline
// control for bubbles.
//
// Handshake: an MDU result transfers on a cycle where mdu_valid && mdu_ready.
// The MDU holds mdu_data/mdu_reg stable until that cycle. The pipe side has no
// handshake and is never dropped or delayed.
//
// Optional feature: define WB_ARB_STATS_EN to add the saturating counters
// stat_stall_cyc and stat_mdu_wr.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_regwrite,
  input  logic              pipe_memtoreg,
  input  logic [DATA_W-1:0] pipe_memdata,
  input  logic [DATA_W-1:0] pipe_alu_result,
  input  logic [ADDR_W-1:0] pipe_writereg,
  input  logic              mdu_valid,
  input  logic [DATA_W-1:0] mdu_data,
  input  logic [ADDR_W-1:0] mdu_reg,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_reg,
  output logic              stall_req,
`ifdef WB_ARB_STATS_EN
  output logic [15:0]       stat_stall_cyc,
  output logic [15:0]       stat_mdu_wr,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_STARVED = 2'd2
  } state_t;

  localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [ADDR_W-1:0]   hold_reg_q, hold_reg_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mdu_wr;
  logic                mdu_acc;
  logic [DATA_W-1:0]   pipe_wdata;

  assign pipe_wdata = pipe_memtoreg ? pipe_memdata : pipe_alu_result;
  assign mdu_ready  = (state_q == ST_EMPTY);
  assign mdu_acc    = mdu_valid && mdu_ready;
  assign pend_valid = (state_q != ST_EMPTY);
  assign pend_reg   = pend_valid ? hold_reg_q : '0;
  assign stall_req  = (state_q == ST_STARVED);
  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign dbg_state  = state_q;

  // Slot arbitration and hold-register FSM next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_reg_d  = hold_reg_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    mdu_wr      = 1'b0;
    if (pipe_regwrite) begin
      // Pipe owns the slot even when its write to r0 is suppressed.
      we_d    = (pipe_writereg != '0);
      waddr_d = pipe_writereg;
      wdata_d = pipe_wdata;
      case (state_q)
        ST_EMPTY: begin
          // An MDU result to r0 is accepted and discarded, never parked.
          if (mdu_acc && (mdu_reg != '0)) begin
            hold_data_d = mdu_data;
            hold_reg_d  = mdu_reg;
            cnt_d       = 4'd1;
            state_d     = (MAX_C <= 4'd1) ? ST_STARVED : ST_PENDING;
          end
        end
        default: begin
          if (pipe_writereg == hold_reg_q) begin
            // Younger pipe write to the same register supersedes the parked one.
            state_d = ST_EMPTY;
            cnt_d   = '0;
          end else if (cnt_q < MAX_C) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 >= MAX_C) state_d = ST_STARVED;
          end
        end
      endcase
    end else if (state_q != ST_EMPTY) begin
      we_d    = 1'b1;
      waddr_d = hold_reg_q;
      wdata_d = hold_data_q;
      mdu_wr  = 1'b1;
      state_d = ST_EMPTY;
      cnt_d   = '0;
    end else if (mdu_acc) begin
      // Bypass: free slot and empty hold, write the arriving result directly.
      we_d    = (mdu_reg != '0);
      waddr_d = mdu_reg;
      wdata_d = mdu_data;
      mdu_wr  = (mdu_reg != '0);
    end
  end

  // State, hold register and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_reg_q  <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_reg_q  <= hold_reg_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [15:0] stall_cyc_q, mdu_wr_cnt_q;
  assign stat_stall_cyc = stall_cyc_q;
  assign stat_mdu_wr    = mdu_wr_cnt_q;

  // Saturating counters of starved cycles and completed MDU writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q  <= '0;
      mdu_wr_cnt_q <= '0;
    end else begin
      if (stall_req && (stall_cyc_q != 16'hFFFF)) stall_cyc_q <= stall_cyc_q + 16'd1;
      if (mdu_wr && (mdu_wr_cnt_q != 16'hFFFF)) mdu_wr_cnt_q <= mdu_wr_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (STARVE_MAX=4).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_regwrite, pipe_memtoreg;
  logic [31:0] pipe_memdata, pipe_alu_result;
  logic [4:0]  pipe_writereg;
  logic        mdu_valid;
  logic [31:0] mdu_data;
  logic [4:0]  mdu_reg;
  logic        mdu_ready, rf_we, pend_valid, stall_req;
  logic [4:0]  rf_waddr, pend_reg;
  logic [31:0] rf_wdata;
  logic [1:0]  dbg_state;
`ifdef WB_ARB_STATS_EN
  logic [15:0] stat_stall_cyc, stat_mdu_wr;
`endif

  int total = 0;
  int bad   = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_regwrite(pipe_regwrite), .pipe_memtoreg(pipe_memtoreg),
    .pipe_memdata(pipe_memdata), .pipe_alu_result(pipe_alu_result),
    .pipe_writereg(pipe_writereg),
    .mdu_valid(mdu_valid), .mdu_data(mdu_data), .mdu_reg(mdu_reg),
    .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_reg(pend_reg), .stall_req(stall_req),
`ifdef WB_ARB_STATS_EN
    .stat_stall_cyc(stat_stall_cyc), .stat_mdu_wr(stat_mdu_wr),
`endif
    .dbg_state(dbg_state)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_set(input logic we, input logic m2r, input logic [4:0] r,
                          input logic [31:0] md, input logic [31:0] alu);
    pipe_regwrite   = we;
    pipe_memtoreg   = m2r;
    pipe_writereg   = r;
    pipe_memdata    = md;
    pipe_alu_result = alu;
  endtask

  task automatic mdu_set(input logic v, input logic [4:0] r, input logic [31:0] d);
    mdu_valid = v;
    mdu_reg   = r;
    mdu_data  = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with inputs active
    rst = 1'b1;
    pipe_set(1'b1, 1'b1, 5'd6, 32'h1111_1111, 32'h2222_2222);
    mdu_set(1'b1, 5'd8, 32'h3333_3333);
    tick();
    tick();
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_mdu_ready", mdu_ready, 1);
    chk("rst_stall", stall_req, 0);
    chk("rst_pend", pend_valid, 0);
    pipe_set(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    mdu_set(1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_we", rf_we, 0);

    // 2: pipe write with memtoreg
    pipe_set(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h1);
    tick();
    chk("p_we", rf_we, 1);
    chk("p_waddr", rf_waddr, 5);
    chk("p_wdata", rf_wdata, 32'hDEAD_BEEF);
    // ALU select
    pipe_set(1'b1, 1'b0, 5'd2, 32'hDEAD_BEEF, 32'h0000_00A5);
    tick();
    chk("alu_wdata", rf_wdata, 32'h0000_00A5);
    pipe_set(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

    // 3: MDU bypass on idle pipe
    mdu_set(1'b1, 5'd7, 32'h1234);
    #1;
    chk("byp_ready", mdu_ready, 1);
    tick();
    mdu_set(1'b0, 5'd0, 32'h0);
    chk("byp_we", rf_we, 1);
    chk("byp_waddr", rf_waddr, 7);
    chk("byp_wdata", rf_wdata, 32'h1234);
    chk("byp_pend", pend_valid, 0);
    tick();
    chk("idle2_we", rf_we, 0);
    chk("idle2_hold_addr", rf_waddr, 7);
    chk("idle2_hold_data", rf_wdata, 32'h1234);

    // 4: starvation
    mdu_set(1'b1, 5'd9, 32'h99);
    pipe_set(1'b1, 1'b0, 5'd3, 32'h0, 32'h30);
    tick();
    mdu_set(1'b0, 5'd0, 32'h0);
    chk("park_we", rf_we, 1);
    chk("park_waddr", rf_waddr, 3);
    chk("park_pend", pend_valid, 1);
    chk("park_pend_reg", pend_reg, 9);
    chk("park_ready", mdu_ready, 0);
    chk("park_stall", stall_req, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("starve_stall_%0d", i), stall_req, (i >= 3) ? 1 : 0);
      chk($sformatf("starve_pipe_we_%0d", i), rf_we, 1);
    end
    pipe_set(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("drain_we", rf_we, 1);
    chk("drain_waddr", rf_waddr, 9);
    chk("drain_wdata", rf_wdata, 32'h99);
    chk("drain_stall", stall_req, 0);
    chk("drain_pend", pend_valid, 0);
    chk("drain_pend_reg", pend_reg, 0);
    chk("drain_ready", mdu_ready, 1);
`ifdef WB_ARB_STATS_EN
    chk("stat_stall", stat_stall_cyc, 3);
    chk("stat_mdu", stat_mdu_wr, 2);
`endif

    // 5: supersede
    mdu_set(1'b1, 5'd4, 32'hAA);
    pipe_set(1'b1, 1'b0, 5'd6, 32'h0, 32'h66);
    tick();
    mdu_set(1'b0, 5'd0, 32'h0);
    chk("sup_park_reg", pend_reg, 4);
    pipe_set(1'b1, 1'b0, 5'd4, 32'h0, 32'hBB);
    tick();
    chk("sup_we", rf_we, 1);
    chk("sup_waddr", rf_waddr, 4);
    chk("sup_wdata", rf_wdata, 32'hBB);
    chk("sup_pend", pend_valid, 0);
    chk("sup_ready", mdu_ready, 1);
    pipe_set(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("sup_no_aa", rf_we, 0);
    chk("sup_hold_data", rf_wdata, 32'hBB);

    // 6: register 0
    mdu_set(1'b1, 5'd0, 32'h55);
    #1;
    chk("r0_ready", mdu_ready, 1);
    tick();
    mdu_set(1'b0, 5'd0, 32'h0);
    chk("r0_mdu_we", rf_we, 0);
    chk("r0_mdu_pend", pend_valid, 0);
    chk("r0_mdu_ready", mdu_ready, 1);
    pipe_set(1'b1, 1'b0, 5'd0, 32'h0, 32'h77);
    tick();
    chk("r0_pipe_we", rf_we, 0);
    // MDU to r0 while pipe writes: discarded, not parked
    mdu_set(1'b1, 5'd0, 32'h56);
    pipe_set(1'b1, 1'b0, 5'd1, 32'h0, 32'h11);
    tick();
    mdu_set(1'b0, 5'd0, 32'h0);
    chk("r0_lost_pend", pend_valid, 0);
    chk("r0_lost_we", rf_we, 1);

    // Reset mid-operation discards parked result
    mdu_set(1'b1, 5'd10, 32'hCAFE);
    pipe_set(1'b1, 1'b0, 5'd11, 32'h0, 32'hB0);
    tick();
    mdu_set(1'b0, 5'd0, 32'h0);
    pipe_set(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("mid_pend", pend_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_pend", pend_valid, 0);
    chk("mid_rst_we", rf_we, 0);
    tick();
    chk("mid_after_we", rf_we, 0);
    chk("mid_after_ready", mdu_ready, 1);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
